instr_reg_write_arb: RTL and testbench

INSTR_REG_WRITE_ARB -- requirements
Module: instr_reg_write_arb

---
 rtl/instr_reg_write_arb.sv | 158 +++++++++++++++
 tb/tb_instr_reg_write_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_reg_write_arb.sv
// Two-port write arbiter feeding a 32-entry instruction register.
// Requester A and B compete for one write slot per cycle. When both are valid,
// a priority token decides the winner and then passes to the loser. The granted
// opcode and operands are registered and presented with load_en one cycle later.
// When WRAP_EN = 0 the arbiter stops accepting once 32 entries are written and
// waits for clear. When WRAP_EN = 1 it keeps accepting and overwrites from 0.
//
// state | meaning
// IDLE  | no transfer accepted last cycle
// WRITE | a transfer was accepted last cycle (load_en high now)
// FULL  | 32 entries written with wrapping disabled; only clear leaves

module instr_reg_write_arb #(
    parameter bit WRAP_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               req_a_valid,
    input  logic               req_b_valid,
    output logic               req_a_ready,
    output logic               req_b_ready,
    input  logic [3:0]         req_a_opcode,
    input  logic [3:0]         req_b_opcode,
    input  logic signed [31:0] req_a_operand_a,
    input  logic signed [31:0] req_a_operand_b,
    input  logic signed [31:0] req_b_operand_a,
    input  logic signed [31:0] req_b_operand_b,
    output logic               load_en,
    output logic [4:0]         write_pointer,
    output logic [3:0]         opcode,
    output logic signed [31:0] operand_a,
    output logic signed [31:0] operand_b,
    output logic [5:0]         entry_count,
    output logic               full,
    output logic               grant_id
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [5:0] COUNT_MAX = 6'd32;

    state_t             state_q, state_d;
    logic [4:0]         ptr_q, ptr_d;
    logic [5:0]         count_q, count_d;
    logic               token_q, token_d;
    logic               load_en_q, load_en_d;
    logic [4:0]         wp_q, wp_d;
    logic [3:0]         op_q, op_d;
    logic signed [31:0] opa_q, opa_d;
    logic signed [31:0] opb_q, opb_d;
    logic               gid_q, gid_d;

    logic accept_ok;
    logic grant_a;
    logic grant_b;
    logic xfer;
    logic stop_now;

    // Ready is purely combinational; reset_n is folded in so no handshake
    // can complete while the block is held in reset.
    always_comb begin
        accept_ok   = reset_n & ~clear & (state_q != S_FULL);
        grant_b     = req_b_valid & (~req_a_valid | token_q);
        grant_a     = req_a_valid & ~grant_b;
        req_a_ready = accept_ok & grant_a;
        req_b_ready = accept_ok & grant_b;
        xfer        = req_a_ready | req_b_ready;
    end

    // Next-state computation for pointer, count, token, write data and FSM.
    always_comb begin
        ptr_d     = ptr_q;
        count_d   = count_q;
        token_d   = token_q;
        load_en_d = 1'b0;
        wp_d      = wp_q;
        op_d      = op_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        gid_d     = gid_q;
        state_d   = state_q;
        stop_now  = 1'b0;

        if (clear) begin
            ptr_d   = 5'd0;
            count_d = 6'd0;
            token_d = 1'b0;
            state_d = S_IDLE;
        end else begin
            if (xfer) begin
                load_en_d = 1'b1;
                wp_d      = ptr_q;
                gid_d     = req_b_ready;
                op_d      = req_b_ready ? req_b_opcode    : req_a_opcode;
                opa_d     = req_b_ready ? req_b_operand_a : req_a_operand_a;
                opb_d     = req_b_ready ? req_b_operand_b : req_a_operand_b;
                ptr_d     = ptr_q + 5'd1;
                count_d   = (count_q == COUNT_MAX) ? COUNT_MAX : count_q + 6'd1;
                // Token goes to whichever side lost (or did not ask) this time.
                token_d   = ~req_b_ready;
                stop_now  = !WRAP_EN && (count_d == COUNT_MAX);
            end

            case (state_q)
                S_IDLE, S_WRITE: begin
                    if (xfer)
                        state_d = stop_now ? S_FULL : S_WRITE;
                    else
                        state_d = S_IDLE;
                end
                S_FULL:  state_d = S_FULL;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and registered outputs; an async reset drops any pending write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= 5'd0;
            count_q   <= 6'd0;
            token_q   <= 1'b0;
            load_en_q <= 1'b0;
            wp_q      <= 5'd0;
            op_q      <= 4'd0;
            opa_q     <= 32'sd0;
            opb_q     <= 32'sd0;
            gid_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            token_q   <= token_d;
            load_en_q <= load_en_d;
            wp_q      <= wp_d;
            op_q      <= op_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            gid_q     <= gid_d;
        end
    end

    assign load_en       = load_en_q;
    assign write_pointer = wp_q;
    assign opcode        = op_q;
    assign operand_a     = opa_q;
    assign operand_b     = opb_q;
    assign entry_count   = count_q;
    assign full          = (count_q == COUNT_MAX);
    assign grant_id      = gid_q;

endmodule

// File: tb/tb_instr_reg_write_arb.sv
// Bench for instr_reg_write_arb. Two instances share stimulus: index 0 wraps,
// index 1 stops at 32 entries. A behavioural model tracks each instance.
module tb_instr_reg_write_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n;
    logic               clear;
    logic               va, vb;
    logic [3:0]         a_op, b_op;
    logic signed [31:0] a_a, a_b, b_a, b_b;

    logic               rdy_a [2];
    logic               rdy_b [2];
    logic               le    [2];
    logic [4:0]         wp    [2];
    logic [3:0]         op    [2];
    logic signed [31:0] oa    [2];
    logic signed [31:0] ob    [2];
    logic [5:0]         cnt   [2];
    logic               fl    [2];
    logic               gid   [2];

    instr_reg_write_arb #(.WRAP_EN(1'b1)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .req_a_valid(va), .req_b_valid(vb),
        .req_a_ready(rdy_a[0]), .req_b_ready(rdy_b[0]),
        .req_a_opcode(a_op), .req_b_opcode(b_op),
        .req_a_operand_a(a_a), .req_a_operand_b(a_b),
        .req_b_operand_a(b_a), .req_b_operand_b(b_b),
        .load_en(le[0]), .write_pointer(wp[0]), .opcode(op[0]),
        .operand_a(oa[0]), .operand_b(ob[0]), .entry_count(cnt[0]),
        .full(fl[0]), .grant_id(gid[0])
    );

    instr_reg_write_arb #(.WRAP_EN(1'b0)) dut_stop (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .req_a_valid(va), .req_b_valid(vb),
        .req_a_ready(rdy_a[1]), .req_b_ready(rdy_b[1]),
        .req_a_opcode(a_op), .req_b_opcode(b_op),
        .req_a_operand_a(a_a), .req_a_operand_b(a_b),
        .req_b_operand_a(b_a), .req_b_operand_b(b_b),
        .load_en(le[1]), .write_pointer(wp[1]), .opcode(op[1]),
        .operand_a(oa[1]), .operand_b(ob[1]), .entry_count(cnt[1]),
        .full(fl[1]), .grant_id(gid[1])
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state, one slot per instance.
    int          m_cnt [2];
    int          m_ptr [2];
    int          m_tok [2];
    int          m_le  [2];
    int          m_wp  [2];
    int          m_gid [2];
    logic [3:0]  m_op  [2];
    logic [31:0] m_a   [2];
    logic [31:0] m_b   [2];

    // Readies as seen during the last step, for scenario checks.
    logic smp_ra [2];
    logic smp_rb [2];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s[dut%0d] got %0h expected %0h at %0t", nm, idx, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_ptr[i] = 0; m_tok[i] = 0; m_le[i] = 0;
            m_wp[i] = 0; m_gid[i] = 0; m_op[i] = '0; m_a[i] = '0; m_b[i] = '0;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            chk("load_en",       i, 32'(le[i]),  32'(m_le[i]));
            chk("write_pointer", i, 32'(wp[i]),  32'(m_wp[i]));
            chk("grant_id",      i, 32'(gid[i]), 32'(m_gid[i]));
            chk("opcode",        i, 32'(op[i]),  32'(m_op[i]));
            chk("operand_a",     i, oa[i],       m_a[i]);
            chk("operand_b",     i, ob[i],       m_b[i]);
            chk("entry_count",   i, 32'(cnt[i]), 32'(m_cnt[i]));
            chk("full",          i, 32'(fl[i]),  32'(m_cnt[i] == 32));
        end
    endtask

    // One clock cycle: entered and left at a negedge.
    task automatic step(input logic a_v, input logic b_v, input logic clr,
                        input logic [3:0] oa_i, input logic [3:0] ob_i,
                        input logic [31:0] aa, input logic [31:0] ab,
                        input logic [31:0] ba, input logic [31:0] bb);
        bit ok, ga, gb;
        va = a_v; vb = b_v; clear = clr;
        a_op = oa_i; b_op = ob_i; a_a = aa; a_b = ab; b_a = ba; b_b = bb;
        #1;
        for (int i = 0; i < 2; i++) begin
            ok = !clr && !(i == 1 && m_cnt[i] == 32);
            ga = a_v && (!b_v || m_tok[i] == 0);
            gb = b_v && (!a_v || m_tok[i] == 1);
            smp_ra[i] = rdy_a[i];
            smp_rb[i] = rdy_b[i];
            chk("req_a_ready", i, 32'(rdy_a[i]), 32'(ok && ga));
            chk("req_b_ready", i, 32'(rdy_b[i]), 32'(ok && gb));
            if (clr) begin
                m_cnt[i] = 0; m_ptr[i] = 0; m_tok[i] = 0; m_le[i] = 0;
            end else if (ok && (ga || gb)) begin
                m_le[i]  = 1;
                m_wp[i]  = m_ptr[i];
                m_gid[i] = gb ? 1 : 0;
                m_op[i]  = gb ? ob_i : oa_i;
                m_a[i]   = gb ? ba : aa;
                m_b[i]   = gb ? bb : ab;
                m_ptr[i] = (m_ptr[i] + 1) % 32;
                m_cnt[i] = (m_cnt[i] < 32) ? m_cnt[i] + 1 : 32;
                m_tok[i] = gb ? 0 : 1;
            end else begin
                m_le[i] = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic step_ab(input logic a_v, input logic b_v, input logic clr);
        step(a_v, b_v, clr, 4'd3, 4'd9, 32'sd5, 32'sd7, -32'sd2, 32'sd100);
    endtask

    typedef struct {
        logic va, vb, clr;
        logic ra, rb, le;
        int   wp, gid, cnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic       rva, rvb, rclr;
        logic [3:0] r_oa, r_ob;

        tbl[0]  = '{1, 0, 0,  1, 0, 1,  0, 0, 1};
        tbl[1]  = '{1, 0, 0,  1, 0, 1,  1, 0, 2};
        tbl[2]  = '{1, 0, 0,  1, 0, 1,  2, 0, 3};
        tbl[3]  = '{0, 0, 0,  0, 0, 0,  2, 0, 3};
        tbl[4]  = '{1, 1, 1,  0, 0, 0,  2, 0, 0};
        tbl[5]  = '{1, 1, 0,  1, 0, 1,  0, 0, 1};
        tbl[6]  = '{1, 1, 0,  0, 1, 1,  1, 1, 2};
        tbl[7]  = '{1, 1, 0,  1, 0, 1,  2, 0, 3};
        tbl[8]  = '{1, 1, 0,  0, 1, 1,  3, 1, 4};
        tbl[9]  = '{0, 1, 0,  0, 1, 1,  4, 1, 5};
        tbl[10] = '{1, 0, 0,  1, 0, 1,  5, 0, 6};
        tbl[11] = '{0, 0, 1,  0, 0, 0,  5, 0, 0};

        // Reset with both requesters asserting: no ready, all outputs zero.
        reset_n = 1'b0; clear = 1'b0; va = 1'b1; vb = 1'b1;
        a_op = 4'hF; b_op = 4'hE; a_a = 32'sd1; a_b = 32'sd2; b_a = 32'sd3; b_b = 32'sd4;
        model_reset();
        #3;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready_a", i, 32'(rdy_a[i]), 32'd0);
            chk("rst_ready_b", i, 32'(rdy_b[i]), 32'd0);
        end
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed table: single requester, idle hold, clear, contention, single B.
        for (int r = 0; r < 12; r++) begin
            step_ab(tbl[r].va, tbl[r].vb, tbl[r].clr);
            for (int i = 0; i < 2; i++) begin
                chk("tbl_ready_a", r, 32'(smp_ra[i]), 32'(tbl[r].ra));
                chk("tbl_ready_b", r, 32'(smp_rb[i]), 32'(tbl[r].rb));
                chk("tbl_load_en", r, 32'(le[i]),     32'(tbl[r].le));
                chk("tbl_wp",      r, 32'(wp[i]),     32'(tbl[r].wp));
                chk("tbl_gid",     r, 32'(gid[i]),    32'(tbl[r].gid));
                chk("tbl_cnt",     r, 32'(cnt[i]),    32'(tbl[r].cnt));
                chk("tbl_opcode",  r, 32'(op[i]),     tbl[r].gid ? 32'd9 : 32'd3);
                chk("tbl_oper_a",  r, oa[i],          tbl[r].gid ? -32'sd2 : 32'sd5);
                chk("tbl_oper_b",  r, ob[i],          tbl[r].gid ? 32'sd100 : 32'sd7);
            end
        end

        // Fill to 32, then a 33rd request: wrap instance overwrites 0, stop instance refuses.
        for (int k = 0; k < 32; k++)
            step(1'b1, 1'b0, 1'b0, 4'(k), 4'd0, 32'(k * 3), -32'(k), 32'd0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            chk("fill_full", i, 32'(fl[i]),  32'd1);
            chk("fill_wp31", i, 32'(wp[i]),  32'd31);
        end
        step(1'b1, 1'b0, 1'b0, 4'd7, 4'd0, 32'd77, 32'd88, 32'd0, 32'd0);
        chk("wrap_ready",   0, 32'(smp_ra[0]), 32'd1);
        chk("wrap_wp0",     0, 32'(wp[0]),     32'd0);
        chk("wrap_cnt",     0, 32'(cnt[0]),    32'd32);
        chk("wrap_full",    0, 32'(fl[0]),     32'd1);
        chk("stop_ready",   1, 32'(smp_ra[1]), 32'd0);
        chk("stop_no_load", 1, 32'(le[1]),     32'd0);
        step_ab(1'b1, 1'b1, 1'b0);
        chk("stop_no_load2", 1, 32'(le[1]), 32'd0);
        step_ab(1'b1, 1'b1, 1'b1);
        step_ab(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("post_clear_wp",  i, 32'(wp[i]),  32'd0);
            chk("post_clear_cnt", i, 32'(cnt[i]), 32'd1);
            chk("post_clear_le",  i, 32'(le[i]),  32'd1);
        end

        // Reset while a write is being presented: outputs drop at once.
        step_ab(1'b0, 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            chk("midrst_load_en", i, 32'(le[i]),  32'd0);
            chk("midrst_ready_b", i, 32'(rdy_b[i]), 32'd0);
        end
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step_ab(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("after_rst_gid", i, 32'(gid[i]), 32'd0);
            chk("after_rst_wp",  i, 32'(wp[i]),  32'd0);
        end

        // Clear with both valid: token returns to A even though B was next.
        step_ab(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            chk("clr_ready_a", i, 32'(smp_ra[i]), 32'd0);
            chk("clr_ready_b", i, 32'(smp_rb[i]), 32'd0);
            chk("clr_no_load", i, 32'(le[i]),     32'd0);
        end
        step_ab(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("clr_then_gid", i, 32'(gid[i]), 32'd0);
            chk("clr_then_wp",  i, 32'(wp[i]),  32'd0);
        end

        // Random traffic against the model.
        for (int k = 0; k < 800; k++) begin
            rva  = 1'($urandom_range(0, 3) != 0);
            rvb  = 1'($urandom_range(0, 1));
            rclr = 1'($urandom_range(0, 79) == 0);
            r_oa = 4'($urandom);
            r_ob = 4'($urandom);
            step(rva, rvb, rclr, r_oa, r_ob, $urandom, $urandom, $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
